// File: rtl/sd_host_pkg.sv
// Shared SD host definitions: command-line state encoding, frame widths and the serial CRC7 step.
// No latency or flow control of its own; consumed by the CMD and DAT line blocks.
package sd_host_pkg;

    localparam int CMD_FRAME_W  = 48;
    localparam int CMD_CRC_SPAN = 40;
    localparam int CRC7_W       = 7;

    // x^7 + x^3 + 1 with the x^7 term implied by the shift
    localparam logic [CRC7_W-1:0] CRC7_POLY = 7'h09;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TX   = 3'd1,
        ST_TURN = 3'd2,
        ST_WAIT = 3'd3,
        ST_RX   = 3'd4,
        ST_GAP  = 3'd5
    } cmd_state_t;

    function automatic logic [CRC7_W-1:0] crc7_next(input logic [CRC7_W-1:0] crc,
                                                    input logic              din);
        logic fb;
        fb = crc[CRC7_W-1] ^ din;
        return {crc[CRC7_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : '0);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7, MSB-first; one bit folded in per enabled cycle, result visible the next cycle.
// No backpressure: clr has priority over en.
module sd_crc7
    import sd_host_pkg::*;
(
    input  logic              FFCLK,
    input  logic              FFCLR,
    input  logic              clr,
    input  logic              en,
    input  logic              bit_in,
    output logic [CRC7_W-1:0] crc
);

    always_ff @(posedge FFCLK or posedge FFCLR) begin
        if (FFCLR) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc7_next(crc, bit_in);
        end
    end

endmodule

// File: rtl/sd_cmd_line_ctrl.sv
// SDIO CMD-line sequencer: sends a 48-bit command, releases the line, captures an optional R1/R7-style response, then holds the Ncc gap.
// Paced by sd_tick (one bit per tick); cmd_start is only accepted in IDLE, with no queuing while busy.
module sd_cmd_line_ctrl
    import sd_host_pkg::*;
#(
    parameter int NCR_MAX  = 64,
    parameter int NCC_MIN  = 8,
    parameter int TURN_CYC = 2
) (
    input  logic        FFCLK,
    input  logic        FFCLR,
    input  logic        sd_tick,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        resp_en,
    output logic        cmd_busy,
    output logic        cmd_done,
    output logic        resp_timeout,
    output logic        resp_crc_err,
    output logic [5:0]  resp_index,
    output logic [31:0] resp_arg,
    output logic        pad_a2,
    output logic        pad_o_en,
    output logic        pad_en,
    input  logic        pad_in
);

    localparam int TICK_MAX = (NCR_MAX > NCC_MIN)
                            ? ((NCR_MAX > TURN_CYC) ? NCR_MAX : TURN_CYC)
                            : ((NCC_MIN > TURN_CYC) ? NCC_MIN : TURN_CYC);
    localparam int CNT_W    = $clog2(TICK_MAX + 1);

    localparam logic [CNT_W-1:0] NCR_LAST  = CNT_W'(NCR_MAX - 1);
    localparam logic [CNT_W-1:0] NCC_LAST  = CNT_W'(NCC_MIN - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYC - 1);
    localparam logic [5:0]       CRC_EDGE  = 6'd8;

    cmd_state_t                state, state_nxt;
    logic [5:0]                bit_cnt;
    logic [CNT_W-1:0]          tick_cnt;
    logic [CMD_CRC_SPAN-1:0]   tx_sh;
    logic [CMD_FRAME_W-3:0]    rx_sh;
    logic [CMD_FRAME_W-2:0]    rx_bits;
    logic                      rsp_en_q;
    logic [CRC7_W-1:0]         crc;
    logic                      crc_clr;
    logic                      crc_en;
    logic                      crc_bit;
    logic [2:0]                crc_sel;
    logic                      crc_bad;

    // Start bit is implicit (always 0); rx_bits[k] is response frame bit k for k = 46..0
    assign rx_bits = {rx_sh, pad_in};
    assign crc_sel = bit_cnt[2:0] - 3'd1;
    assign crc_bad = rx_bits[46] || (crc != rx_bits[7:1]) || !rx_bits[0];

    sd_crc7 u_crc (
        .FFCLK  (FFCLK),
        .FFCLR  (FFCLR),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (crc_bit),
        .crc    (crc)
    );

    always_ff @(posedge FFCLK or posedge FFCLR) begin
        if (FFCLR) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (cmd_start) state_nxt = ST_TX;
            ST_TX:   if (sd_tick && bit_cnt == 6'd0) state_nxt = rsp_en_q ? ST_TURN : ST_GAP;
            ST_TURN: if (sd_tick && tick_cnt == TURN_LAST) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (sd_tick) begin
                    if (!pad_in) begin
                        state_nxt = ST_RX;
                    end else if (tick_cnt == NCR_LAST) begin
                        state_nxt = ST_GAP;
                    end
                end
            end
            ST_RX:   if (sd_tick && bit_cnt == 6'd0) state_nxt = ST_GAP;
            ST_GAP:  if (sd_tick && tick_cnt == NCC_LAST) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_busy = (state != ST_IDLE);
        pad_en   = (state == ST_TX);
        pad_o_en = (state == ST_TX) && sd_tick;
        pad_a2   = 1'b1;
        if (state == ST_TX) begin
            if (bit_cnt >= CRC_EDGE) begin
                pad_a2 = tx_sh[CMD_CRC_SPAN-1];
            end else if (bit_cnt != 6'd0) begin
                pad_a2 = crc[crc_sel];
            end
        end
        // A zero start bit leaves a cleared CRC at zero, so clearing on detection covers it
        crc_clr = ((state == ST_IDLE) && cmd_start) ||
                  ((state == ST_WAIT) && sd_tick && !pad_in);
        crc_en  = sd_tick && (bit_cnt >= CRC_EDGE) && ((state == ST_TX) || (state == ST_RX));
        crc_bit = (state == ST_TX) ? tx_sh[CMD_CRC_SPAN-1] : pad_in;
    end

    always_ff @(posedge FFCLK or posedge FFCLR) begin
        if (FFCLR) begin
            bit_cnt      <= '0;
            tick_cnt     <= '0;
            tx_sh        <= '0;
            rx_sh        <= '0;
            rsp_en_q     <= 1'b0;
            cmd_done     <= 1'b0;
            resp_timeout <= 1'b0;
            resp_crc_err <= 1'b0;
            resp_index   <= '0;
            resp_arg     <= '0;
        end else begin
            cmd_done <= (state == ST_GAP) && sd_tick && (tick_cnt == NCC_LAST);
            case (state)
                ST_IDLE: begin
                    if (cmd_start) begin
                        tx_sh        <= {2'b01, cmd_index, cmd_arg};
                        rsp_en_q     <= resp_en;
                        bit_cnt      <= 6'(CMD_FRAME_W - 1);
                        tick_cnt     <= '0;
                        resp_timeout <= 1'b0;
                        resp_crc_err <= 1'b0;
                    end
                end
                ST_TX: begin
                    if (sd_tick) begin
                        tx_sh <= {tx_sh[CMD_CRC_SPAN-2:0], 1'b0};
                        if (bit_cnt != 6'd0) bit_cnt <= bit_cnt - 6'd1;
                    end
                end
                ST_TURN: begin
                    if (sd_tick) tick_cnt <= (tick_cnt == TURN_LAST) ? '0 : tick_cnt + 1'b1;
                end
                ST_WAIT: begin
                    if (sd_tick) begin
                        if (!pad_in) begin
                            rx_sh    <= '0;
                            bit_cnt  <= 6'(CMD_FRAME_W - 2);
                            tick_cnt <= '0;
                        end else if (tick_cnt == NCR_LAST) begin
                            resp_timeout <= 1'b1;
                            tick_cnt     <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                ST_RX: begin
                    if (sd_tick) begin
                        rx_sh <= rx_bits[CMD_FRAME_W-3:0];
                        if (bit_cnt == 6'd0) begin
                            resp_index   <= rx_bits[45:40];
                            resp_arg     <= rx_bits[39:8];
                            resp_crc_err <= crc_bad;
                        end else begin
                            bit_cnt <= bit_cnt - 6'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (sd_tick) tick_cnt <= (tick_cnt == NCC_LAST) ? '0 : tick_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_line_ctrl.sv
// Randomized bench for sd_cmd_line_ctrl with a tick-level command/card reference model.
// Random sd_tick spacing, noise on pad_in between ticks, and stray cmd_start pulses while busy.
module tb_sd_cmd_line_ctrl;

    localparam int NCR  = 64;
    localparam int NCC  = 8;
    localparam int TURN = 2;

    logic        FFCLK;
    logic        FFCLR;
    logic        sd_tick;
    logic        cmd_start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        resp_en;
    logic        cmd_busy;
    logic        cmd_done;
    logic        resp_timeout;
    logic        resp_crc_err;
    logic [5:0]  resp_index;
    logic [31:0] resp_arg;
    logic        pad_a2;
    logic        pad_o_en;
    logic        pad_en;
    logic        pad_in;

    sd_cmd_line_ctrl #(.NCR_MAX(NCR), .NCC_MIN(NCC), .TURN_CYC(TURN)) dut (
        .FFCLK        (FFCLK),
        .FFCLR        (FFCLR),
        .sd_tick      (sd_tick),
        .cmd_start    (cmd_start),
        .cmd_index    (cmd_index),
        .cmd_arg      (cmd_arg),
        .resp_en      (resp_en),
        .cmd_busy     (cmd_busy),
        .cmd_done     (cmd_done),
        .resp_timeout (resp_timeout),
        .resp_crc_err (resp_crc_err),
        .resp_index   (resp_index),
        .resp_arg     (resp_arg),
        .pad_a2       (pad_a2),
        .pad_o_en     (pad_o_en),
        .pad_en       (pad_en),
        .pad_in       (pad_in)
    );

    initial begin
        FFCLK = 1'b0;
        forever #5 FFCLK = ~FFCLK;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit          m_busy, m_done_now, m_first, m_chk_fields;
    int          m_ticks, c_done_at, c_rx_end, c_d;
    bit          c_resp;
    logic [47:0] c_tx, c_rsp, tx_cap;
    bit          e_to, e_err, e_has_rsp;
    logic [5:0]  e_idx;
    logic [31:0] e_arg;
    int          dut_done, tick_wait, junk_odds;
    bit          req_pend, r_rsp;
    logic [5:0]  r_idx;
    logic [31:0] r_arg;
    int          r_d, r_flip;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1
    function automatic logic [6:0] crc7_ref(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'd0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] mk_frame(input logic [1:0] hd, input logic [5:0] idx,
                                             input logic [31:0] arg);
        logic [39:0] m;
        m = {hd, idx, arg};
        return {m, crc7_ref(m), 1'b1};
    endfunction

    task automatic model_reset();
        m_busy       = 1'b0;
        m_done_now   = 1'b0;
        m_first      = 1'b0;
        m_chk_fields = 1'b0;
        m_ticks      = 0;
        req_pend     = 1'b0;
    endtask

    task automatic cycle();
        int n;
        bit acc;
        @(negedge FFCLK);
        if (tick_wait == 0) begin
            sd_tick   = 1'b1;
            tick_wait = $urandom_range(1, 3);
        end else begin
            sd_tick   = 1'b0;
            tick_wait--;
        end
        if (req_pend && !m_busy) begin
            cmd_start = 1'b1;
            cmd_index = r_idx;
            cmd_arg   = r_arg;
            resp_en   = r_rsp;
        end else if (m_busy && $urandom_range(0, junk_odds) == 0) begin
            cmd_start = 1'b1;
            cmd_index = 6'($urandom);
            cmd_arg   = $urandom;
            resp_en   = 1'($urandom);
        end else begin
            cmd_start = 1'b0;
        end
        if (sd_tick) begin
            pad_in = 1'b1;
            if (m_busy && c_resp && m_ticks >= 48) begin
                n = m_ticks - 48 + 1;
                if (n > c_d && n <= c_d + 48) pad_in = c_rsp[47 - (n - c_d - 1)];
            end
        end else begin
            pad_in = 1'($urandom);
        end
        #1;
        // observe
        chk("cmd_busy", cmd_busy, m_busy);
        chk("cmd_done", cmd_done, m_done_now);
        chk("pad_en", pad_en, m_busy && m_ticks < 48);
        chk("pad_o_en", pad_o_en, m_busy && m_ticks < 48 && sd_tick);
        if (!m_busy) chk("pad_a2_idle", pad_a2, 1);
        if (cmd_done) dut_done++;
        if (m_busy && m_ticks < 48 && sd_tick) begin
            chk("tx_bit", pad_a2, c_tx[47 - m_ticks]);
            tx_cap = {tx_cap[46:0], pad_a2};
        end
        if (m_first) begin
            chk("accept_timeout_clr", resp_timeout, 0);
            chk("accept_crcerr_clr", resp_crc_err, 0);
        end
        if (m_chk_fields) begin
            chk("rx_end_index", resp_index, e_idx);
            chk("rx_end_arg", resp_arg, e_arg);
            chk("rx_end_crc_err", resp_crc_err, e_err);
        end
        if (m_done_now) begin
            chk("done_timeout", resp_timeout, e_to);
            chk("done_crc_err", resp_crc_err, e_err);
            if (e_has_rsp) begin
                chk("done_index", resp_index, e_idx);
                chk("done_arg", resp_arg, e_arg);
            end
        end
        // advance model
        acc          = cmd_start && !m_busy;
        m_first      = 1'b0;
        m_done_now   = 1'b0;
        m_chk_fields = 1'b0;
        if (acc) begin
            c_tx      = mk_frame(2'b01, cmd_index, cmd_arg);
            c_resp    = resp_en;
            e_to      = 1'b0;
            e_err     = 1'b0;
            e_has_rsp = 1'b0;
            c_d       = r_d;
            if (!c_resp) begin
                c_done_at = 48 + NCC;
            end else begin
                c_rsp = mk_frame(2'b00, cmd_index, cmd_arg);
                if (r_flip >= 0) c_rsp[r_flip] = ~c_rsp[r_flip];
                if (c_d + 1 <= TURN + NCR) begin
                    c_rx_end  = 48 + c_d + 1 + 47;
                    c_done_at = c_rx_end + NCC;
                    e_has_rsp = 1'b1;
                    e_idx     = c_rsp[45:40];
                    e_arg     = c_rsp[39:8];
                    e_err     = c_rsp[46] || (crc7_ref(c_rsp[47:8]) != c_rsp[7:1]) || !c_rsp[0];
                end else begin
                    e_to      = 1'b1;
                    c_done_at = 48 + TURN + NCR + NCC;
                end
            end
            req_pend = 1'b0;
            m_busy   = 1'b1;
            m_ticks  = 0;
            m_first  = 1'b1;
            tx_cap   = '0;
        end else if (m_busy && sd_tick) begin
            m_ticks++;
            if (m_ticks == 48) chk("tx_frame", tx_cap, c_tx);
            if (e_has_rsp && m_ticks == c_rx_end) m_chk_fields = 1'b1;
            if (m_ticks == c_done_at) begin
                m_busy     = 1'b0;
                m_done_now = 1'b1;
            end
        end
    endtask

    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit rsp,
                           input int d, input int flip);
        int d0;
        int budget;
        d0       = dut_done;
        r_idx    = idx;
        r_arg    = arg;
        r_rsp    = rsp;
        r_d      = d;
        r_flip   = flip;
        req_pend = 1'b1;
        budget   = 0;
        while (dut_done == d0 && budget < 3000) begin
            cycle();
            budget++;
        end
        repeat (4 + $urandom_range(0, 3)) cycle();
        chk("done_count", dut_done - d0, 1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_busy"}, cmd_busy, 0);
        chk({tag, "_done"}, cmd_done, 0);
        chk({tag, "_timeout"}, resp_timeout, 0);
        chk({tag, "_crc_err"}, resp_crc_err, 0);
        chk({tag, "_index"}, resp_index, 0);
        chk({tag, "_arg"}, resp_arg, 0);
        chk({tag, "_pad_a2"}, pad_a2, 1);
        chk({tag, "_pad_o_en"}, pad_o_en, 0);
        chk({tag, "_pad_en"}, pad_en, 0);
    endtask

    initial begin
        int budget;
        int mode;
        FFCLR     = 1'b1;
        sd_tick   = 1'b0;
        cmd_start = 1'b0;
        cmd_index = '0;
        cmd_arg   = '0;
        resp_en   = 1'b0;
        pad_in    = 1'b1;
        dut_done  = 0;
        tick_wait = 0;
        junk_odds = 15;
        tx_cap    = '0;
        model_reset();
        repeat (3) @(negedge FFCLK);
        #1;
        chk_reset_values("reset");
        @(negedge FFCLK);
        FFCLR = 1'b0;
        #1;
        chk_reset_values("post_reset");

        // CMD0, no response
        run_cmd(6'd0, 32'h0, 1'b0, 0, -1);
        chk("cmd0_frame", tx_cap, 48'h40_0000_0000_95);

        // CMD8 with a valid R7 after 5 ticks
        run_cmd(6'd8, 32'h0000_01AA, 1'b1, 5, -1);
        chk("cmd8_crc_byte", tx_cap[7:0], 8'h87);
        chk("cmd8_resp_index", resp_index, 6'd8);
        chk("cmd8_resp_arg", resp_arg, 32'h0000_01AA);
        chk("cmd8_crc_err", resp_crc_err, 0);

        // silent card: timeout
        run_cmd(6'd8, 32'h0000_01AA, 1'b1, 1000, -1);
        chk("timeout_flag", resp_timeout, 1);

        // one argument bit flipped
        run_cmd(6'd8, 32'h0000_01AA, 1'b1, 5, 12);
        chk("crc_err_flag", resp_crc_err, 1);
        chk("crc_err_arg", resp_arg, 32'h0000_01AA ^ (32'h1 << 4));

        // start bit on the last WAIT tick, then one tick too late
        run_cmd(6'd17, 32'hDEAD_BEEF, 1'b1, TURN + NCR - 1, -1);
        chk("ncr_edge_no_timeout", resp_timeout, 0);
        run_cmd(6'd17, 32'hDEAD_BEEF, 1'b1, TURN + NCR, -1);
        chk("ncr_edge_timeout", resp_timeout, 1);

        // heavy stray requests while busy
        junk_odds = 3;
        run_cmd(6'd55, 32'h1234_5678, 1'b1, 9, -1);
        run_cmd(6'd0, 32'h0, 1'b0, 0, -1);
        junk_odds = 15;

        // reset while the bit counter sits at 20
        r_idx = 6'd8; r_arg = 32'h0000_01AA; r_rsp = 1'b0; r_d = 0; r_flip = -1;
        req_pend = 1'b1;
        budget   = 0;
        while (!(m_busy && m_ticks == 27) && budget < 1000) begin
            cycle();
            budget++;
        end
        FFCLR = 1'b1;
        #1;
        chk("midframe_pad_en", pad_en, 0);
        chk("midframe_busy", cmd_busy, 0);
        chk("midframe_pad_o_en", pad_o_en, 0);
        @(negedge FFCLK);
        FFCLR = 1'b0;
        model_reset();
        run_cmd(6'd0, 32'h0, 1'b0, 0, -1);
        chk("after_reset_cmd0", tx_cap, 48'h40_0000_0000_95);

        // random mix
        for (int k = 0; k < 25; k++) begin
            mode = $urandom_range(0, 4);
            case (mode)
                0: run_cmd(6'($urandom), $urandom, 1'b0, 0, -1);
                1, 2: run_cmd(6'($urandom), $urandom, 1'b1, $urandom_range(2, 20), -1);
                3: run_cmd(6'($urandom), $urandom, 1'b1, $urandom_range(2, 30), $urandom_range(0, 46));
                default: run_cmd(6'($urandom), $urandom, 1'b1, $urandom_range(66, 80), -1);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sd_cmd_line_ctrl.md
# sd_cmd_line_ctrl

SDIO host command-line sequencer. It serializes a 48-bit command frame (start, direction, index, argument, CRC7, end) onto the CMD output-flopped bidirectional pad cell and releases the line for turnaround. It then samples the card response with an Ncr timeout and enforces the Ncc command-to-command gap. It sits between the host register file and the CMD pad, and is paced by an SD-clock tick from the clock divider.

## Interface
Parameters:
- NCR_MAX, 64: SD-clock periods to wait for a response start bit before timeout.
- NCC_MIN, 8: SD-clock periods of idle line after each command or response.
- TURN_CYC, 2: SD-clock periods the line is released (Z) between end bit and response search.

Ports:
- FFCLK, in, 1: system clock. One clock; reset is asynchronous and active-high.
- FFCLR, in, 1: asynchronous active-high reset.
- sd_tick, in, 1: single-FFCLK pulse once per SD bit period.
- cmd_start, in, 1: request pulse; accepted only in IDLE.
- cmd_index, in, 6: command index, captured at accept.
- cmd_arg, in, 32: argument, captured at accept.
- resp_en, in, 1: 1 expects a 48-bit response; 0 means no response. Captured at accept.
- cmd_busy, out, 1: high from accept until return to IDLE.
- cmd_done, out, 1: one-FFCLK pulse on return to IDLE.
- resp_timeout, out, 1: status for the last command; valid with cmd_done.
- resp_crc_err, out, 1: CRC7, transmission-bit or end-bit error; valid with cmd_done.
- resp_index, out, 6: received index field.
- resp_arg, out, 32: received argument field.
- pad_a2, out, 1: data to the pad cell's A2.
- pad_o_en, out, 1: load enable to the pad cell's output flop.
- pad_en, out, 1: pad output enable (1 = drive).
- pad_in, in, 1: pad input (CMD line level).

## Operation
- States are IDLE, TX, TURN, WAIT, RX and GAP.
- **IDLE:** pad_en=0 and pad_a2=1. On cmd_start, the block latches the inputs, clears both status bits, sets cmd_busy and goes to TX. It builds the 48-bit frame {0,1,index,arg,crc7,1}.
- **CRC7 generation:** polynomial x^7+x^3+1, initial value 0, computed over the first 40 bits MSB-first. It is generated serially during TX or precomputed; the result must match.
- **TX:** pad_en=1 and pad_a2 = current frame bit (MSB first). pad_o_en = sd_tick, so the pad flop advances one bit per tick. The 6-bit bit counter runs 47..0.
  - After the end bit is loaded, the block goes to TURN if resp_en=1, otherwise to GAP.
- **TURN:** pad_en=0 for TURN_CYC ticks, then WAIT.
- **WAIT:** the block samples pad_in on each sd_tick.
  - Sample of 0: counts as the response start bit; go to RX.
  - NCR_MAX ticks with no 0: set resp_timeout and go to GAP.
- **RX:** shifts 47 more bits on sd_tick into a 48-bit shift register.
  - After the last bit it sets resp_crc_err if any of these holds: transmission bit ≠ 0, CRC7 over bits 47..8 ≠ bits 7..1, or end bit ≠ 1.
  - It loads resp_index/resp_arg, then goes to GAP.
  - 136-bit (R2) responses are not supported.
- **GAP:** pad_en=0 for NCC_MIN ticks, then IDLE with a cmd_done pulse.
- cmd_start while cmd_busy=1 is ignored, with no queuing.

## Timing
- **Reset values:** state IDLE, cmd_busy=0, cmd_done=0, resp_timeout=0, resp_crc_err=0, resp_index=0, resp_arg=0, pad_a2=1, pad_o_en=0, pad_en=0.
- **Accept:** cmd_busy rises the FFCLK after cmd_start. The start bit is loaded into the pad flop on the first sd_tick after accept, so it appears at the pad one FFCLK after that tick (pad flop latency).
- **sd_tick coincident with cmd_start:** that tick is not used for TX; the frame starts on the following tick.
- **TX duration:** 48 ticks; pad_en stays 1 through the tick that loads the end bit.
- **WAIT sampling:** pad_in is sampled only on sd_tick cycles.
- **Response fields:** resp_index/resp_arg/resp_crc_err update on the FFCLK after the 48th RX sample and hold until the next accept.
- **Total no-response command:** 48 + NCC_MIN ticks from first tick to cmd_done.
- **FFCLR mid-operation:** immediate return to reset values; the line is released (pad_en=0) asynchronously.
- **Counters:** 6-bit bit counter; Ncr counter sized by $clog2(NCR_MAX+1). No wrap is possible within a state because each state exits at its terminal count.

## Structure
- Shared package `sd_host_pkg` holds:
  - state encoding constants;
  - frame-width constants (48, 40, 7);
  - a CRC7 next-state function, shared with the DAT-line CRC blocks.
- One sub-module is natural: `sd_crc7`, a serial CRC7 with clear/enable/bit inputs and a 7-bit output. It is instanced once for TX and reused for RX, since TX and RX never overlap.

## Test plan
- **CMD0:** index 0, arg 0, resp_en=0 -> pad sequence 0x40 00 00 00 00 95 over 48 ticks. cmd_done follows 8 ticks later; both status bits 0.
- **CMD8 with valid response:** index 8, arg 0x000001AA, resp_en=1 -> TX ends with CRC byte 0x87. Bench card answers after 5 ticks with a valid R7 {0,0,8,0x000001AA,crc,1} -> resp_index=8, resp_arg=0x000001AA, resp_crc_err=0.
- **Timeout:** CMD8, line held high -> resp_timeout=1 after 64 WAIT ticks, then cmd_done after the GAP.
- **CRC error:** same response with one argument bit flipped -> resp_crc_err=1, resp_arg shows the flipped value.
- **Request while busy:** cmd_start during TX -> ignored; transmitted frame and cmd_done count unchanged (exactly one).
- **Reset mid-frame:** FFCLR asserted at TX bit 20 -> pad_en=0, cmd_busy=0 immediately. A new CMD0 after release transmits correctly.
